// File: rtl/ppu_bg_fetcher.sv
// Background fetcher for mode 3: VRAM tile fetch, 8-pixel decode into a
// 16-entry pixel FIFO, and a 160-pixel-per-line output stream.
module ppu_bg_fetcher (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic        bg_ena,
    input  logic        bg_tile_map,
    input  logic        bg_win_tile_data,
    output logic        vram_rd,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic        pix_valid,
    output logic [1:0]  pix,
    output logic [7:0]  pix_x,
    output logic        line_done
);

    typedef enum logic [2:0] {
        IDLE, MAP_REQ, MAP_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, PUSH
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  t_q, t_d;
    logic [7:0]  y_q, y_d;
    logic [4:0]  cx_q, cx_d;
    logic        ena_q, ena_d;
    logic        map_q, map_d;
    logic        tdata_q, tdata_d;
    logic [7:0]  tile_q, tile_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [1:0]  fifo_q [16];
    logic [1:0]  fifo_d [16];
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  disc_q, disc_d;
    logic [7:0]  x_q, x_d;
    logic        act_q, act_d;
    logic        pv_q, pv_d;
    logic [1:0]  pix_q, pix_d;
    logic [7:0]  px_q, px_d;
    logic        ld_q, ld_d;

    logic [4:0]  map_col;
    logic [12:0] map_addr;
    logic [12:0] tile_base;
    logic [12:0] lo_addr;
    logic        pop;
    logic        push;
    logic [4:0]  base;
    logic [3:0]  idx;

    assign map_col  = cx_q + t_q;
    assign map_addr = {2'b11, map_q, y_q[7:3], map_col};
    // 8800 mode: signed tile index around 0x1000, wrapping into 0x0800..0x17F0
    assign tile_base = tdata_q ? {1'b0, tile_q, 4'b0000}
                               : 13'h1000 + {tile_q[7], tile_q, 4'b0000};
    assign lo_addr  = tile_base | {9'b0, y_q[2:0], 1'b0};
    assign pop      = act_q && (cnt_q != 5'd0);
    assign push     = (state_q == PUSH) && (cnt_q <= 5'd8);
    assign base     = cnt_q - {4'b0, pop};

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        y_d       = y_q;
        cx_d      = cx_q;
        ena_d     = ena_q;
        map_d     = map_q;
        tdata_d   = tdata_q;
        tile_d    = tile_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        fifo_d    = fifo_q;
        cnt_d     = base + (push ? 5'd8 : 5'd0);
        disc_d    = disc_q;
        x_d       = x_q;
        act_d     = act_q;
        pv_d      = 1'b0;
        pix_d     = pix_q;
        px_d      = px_q;
        ld_d      = pv_q && (px_q == 8'd159);
        vram_rd   = 1'b0;
        vram_addr = 13'h0;
        idx       = 4'h0;

        unique case (state_q)
            IDLE: ;
            MAP_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = map_addr;
                state_d   = MAP_WAIT;
            end
            MAP_WAIT: begin
                tile_d  = vram_data;
                state_d = LO_REQ;
            end
            LO_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = lo_addr;
                state_d   = LO_WAIT;
            end
            LO_WAIT: begin
                lo_d    = vram_data;
                state_d = HI_REQ;
            end
            HI_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = lo_addr | 13'h1;
                state_d   = HI_WAIT;
            end
            HI_WAIT: begin
                hi_d    = vram_data;
                state_d = PUSH;
            end
            PUSH: begin
                if (push) begin
                    t_d     = t_q + 5'd1;
                    state_d = MAP_REQ;
                end
            end
        endcase

        if (pop) begin
            for (int i = 0; i < 15; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[15] = 2'b00;
        end
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                idx         = base[3:0] + 4'(i);
                fifo_d[idx] = {hi_q[7-i], lo_q[7-i]};
            end
        end

        if (pop) begin
            if (disc_q != 3'd0) begin
                disc_d = disc_q - 3'd1;
            end else begin
                pv_d = 1'b1;
                pix_d = ena_q ? fifo_q[0] : 2'b00;
                px_d = x_q;
                x_d  = x_q + 8'd1;
                if (x_q == 8'd159) begin
                    act_d   = 1'b0;
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            end
        end

        if (line_start) begin
            y_d     = ly + scy;
            cx_d    = scx[7:3];
            disc_d  = scx[2:0];
            ena_d   = bg_ena;
            map_d   = bg_tile_map;
            tdata_d = bg_win_tile_data;
            t_d     = 5'd0;
            cnt_d   = 5'd0;
            x_d     = 8'd0;
            act_d   = 1'b1;
            pv_d    = 1'b0;
            state_d = MAP_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            ena_q   <= 1'b0;
            map_q   <= 1'b0;
            tdata_q <= 1'b0;
            tile_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            for (int i = 0; i < 16; i++) fifo_q[i] <= 2'b00;
            cnt_q   <= '0;
            disc_q  <= '0;
            x_q     <= '0;
            act_q   <= 1'b0;
            pv_q    <= 1'b0;
            pix_q   <= '0;
            px_q    <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            ena_q   <= ena_d;
            map_q   <= map_d;
            tdata_q <= tdata_d;
            tile_q  <= tile_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            fifo_q  <= fifo_d;
            cnt_q   <= cnt_d;
            disc_q  <= disc_d;
            x_q     <= x_d;
            act_q   <= act_d;
            pv_q    <= pv_d;
            pix_q   <= pix_d;
            px_q    <= px_d;
            ld_q    <= ld_d;
        end
    end

    assign pix_valid = pv_q;
    assign pix       = pix_q;
    assign pix_x     = px_q;
    assign line_done = ld_q;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Directed bench for ppu_bg_fetcher: line timing, addressing modes,
// scroll wrap, background disable, mid-line restart and reset.
module tb_ppu_bg_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  ly = 8'd0;
    logic [7:0]  scx = 8'd0;
    logic [7:0]  scy = 8'd0;
    logic        bg_ena = 1'b1;
    logic        bg_tile_map = 1'b0;
    logic        bg_win_tile_data = 1'b1;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data = 8'd0;
    logic        pix_valid;
    logic [1:0]  pix;
    logic [7:0]  pix_x;
    logic        line_done;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] req [$];
    logic [1:0]  pixa [0:159];
    logic [1:0]  pat [0:7];
    int first_v, last_v, nvalid, ld_cyc, nld, gap_err, last_rd, rd_pair;
    bit prev_rd;

    ppu_bg_fetcher dut (
        .clk(clk),
        .reset(reset),
        .line_start(line_start),
        .ly(ly),
        .scx(scx),
        .scy(scy),
        .bg_ena(bg_ena),
        .bg_tile_map(bg_tile_map),
        .bg_win_tile_data(bg_win_tile_data),
        .vram_rd(vram_rd),
        .vram_addr(vram_addr),
        .vram_data(vram_data),
        .pix_valid(pix_valid),
        .pix(pix),
        .pix_x(pix_x),
        .line_done(line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (vram_rd) vram_data <= mem[vram_addr];

    function automatic logic [12:0] get_req(input int k);
        if (k < req.size()) return req[k];
        return 13'bx;
    endfunction

    task automatic fill_mem(input logic [7:0] mapb);
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int i = 13'h1800; i < 8192; i++) mem[i] = mapb;
        mem[13'h0010] = 8'hF0;
        mem[13'h0011] = 8'hCC;
    endtask

    task automatic set_in(input logic [7:0] l, input logic [7:0] sx,
                          input logic [7:0] sy, input logic e,
                          input logic m, input logic d);
        ly = l; scx = sx; scy = sy;
        bg_ena = e; bg_tile_map = m; bg_win_tile_data = d;
    endtask

    task automatic clear_cap();
        req.delete();
        for (int i = 0; i < 160; i++) pixa[i] = 2'bxx;
        first_v = -1; last_v = -1; nvalid = 0; ld_cyc = -1; nld = 0;
        gap_err = 0; last_rd = -1; rd_pair = 0; prev_rd = 1'b0;
    endtask

    // caller sits 1 time unit after a rising edge; this cycle becomes cycle 0
    task automatic start_line();
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            if (vram_rd) begin
                req.push_back(vram_addr);
                if (prev_rd) rd_pair++;
                last_rd = c;
            end
            prev_rd = vram_rd;
            if (pix_valid) begin
                if (nvalid == 0) first_v = c;
                else if (last_v != c - 1) gap_err++;
                if (pix_x != nvalid[7:0]) gap_err++;
                if (pix_x < 8'd160) pixa[pix_x] = pix;
                else gap_err++;
                last_v = c;
                nvalid++;
            end
            if (line_done) begin
                nld++;
                ld_cyc = c;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic int pix_err(input int off);
        int e = 0;
        for (int x = 0; x < 160; x++)
            if (pixa[x] !== pat[(x + off) % 8]) e++;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (vram_rd !== 1'b0 || vram_addr !== 13'h0) begin
            bad++;
            $display("FAIL reset_vram got rd=%b addr=%h want 0/0000", vram_rd, vram_addr);
        end
        total++;
        if ({pix_valid, pix, pix_x, line_done} !== 12'h0) begin
            bad++;
            $display("FAIL reset_pix got v=%b p=%0d x=%0d ld=%b want all 0",
                     pix_valid, pix, pix_x, line_done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_baseline();
        int e;
        fill_mem(8'h01);
        set_in(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (get_req(0) !== 13'h1800 || get_req(1) !== 13'h0010 || get_req(2) !== 13'h0011) begin
            bad++;
            $display("FAIL base_req got %h %h %h want 1800 0010 0011",
                     get_req(0), get_req(1), get_req(2));
        end
        total++;
        if (get_req(3) !== 13'h1801) begin
            bad++;
            $display("FAIL base_map2 got %h want 1801", get_req(3));
        end
        total++;
        if (nvalid !== 160 || gap_err !== 0) begin
            bad++;
            $display("FAIL base_count got n=%0d gaps=%0d want 160/0", nvalid, gap_err);
        end
        total++;
        if (first_v !== 9 || last_v !== 168) begin
            bad++;
            $display("FAIL base_window got %0d..%0d want 9..168", first_v, last_v);
        end
        total++;
        if (ld_cyc !== 169 || nld !== 1) begin
            bad++;
            $display("FAIL base_done got cyc=%0d n=%0d want 169/1", ld_cyc, nld);
        end
        e = pix_err(0);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL base_pix got %0d wrong (pix0=%0d) want 0", e, pixa[0]);
        end
        total++;
        if (rd_pair !== 0 || last_rd >= ld_cyc) begin
            bad++;
            $display("FAIL base_rd got pairs=%0d last=%0d want 0/<%0d", rd_pair, last_rd, ld_cyc);
        end
    endtask

    task automatic test_8800();
        fill_mem(8'h00);
        mem[13'h1800] = 8'h80;
        mem[13'h1801] = 8'h7F;
        set_in(8'd5, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (get_req(1) !== 13'h080A || get_req(2) !== 13'h080B) begin
            bad++;
            $display("FAIL m8800_neg got %h %h want 080a 080b", get_req(1), get_req(2));
        end
        total++;
        if (get_req(4) !== 13'h17FA) begin
            bad++;
            $display("FAIL m8800_pos got %h want 17fa", get_req(4));
        end
    endtask

    task automatic test_scroll();
        int e;
        fill_mem(8'h01);
        set_in(8'd0, 8'hFB, 8'd0, 1'b1, 1'b0, 1'b1);
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (get_req(0) !== 13'h181F || get_req(3) !== 13'h1800) begin
            bad++;
            $display("FAIL scroll_wrap got %h %h want 181f 1800", get_req(0), get_req(3));
        end
        total++;
        if (first_v !== 12 || nvalid !== 160 || gap_err !== 0) begin
            bad++;
            $display("FAIL scroll_first got cyc=%0d n=%0d gaps=%0d want 12/160/0",
                     first_v, nvalid, gap_err);
        end
        total++;
        if (ld_cyc !== 172) begin
            bad++;
            $display("FAIL scroll_done got %0d want 172", ld_cyc);
        end
        e = pix_err(3);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL scroll_pix got %0d wrong (pix0=%0d) want 0", e, pixa[0]);
        end
    endtask

    task automatic test_vwrap();
        fill_mem(8'h00);
        mem[13'h1C00] = 8'h02;
        mem[13'h0028] = 8'hFF;
        set_in(8'd250, 8'd0, 8'd10, 1'b1, 1'b1, 1'b1);
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (get_req(0) !== 13'h1C00 || get_req(3) !== 13'h1C01) begin
            bad++;
            $display("FAIL vwrap_map got %h %h want 1c00 1c01", get_req(0), get_req(3));
        end
        total++;
        if (get_req(1) !== 13'h0028 || get_req(2) !== 13'h0029) begin
            bad++;
            $display("FAIL vwrap_row got %h %h want 0028 0029", get_req(1), get_req(2));
        end
        total++;
        if (pixa[0] !== 2'd1 || pixa[7] !== 2'd1 || pixa[8] !== 2'd0) begin
            bad++;
            $display("FAIL vwrap_pix got %0d %0d %0d want 1 1 0", pixa[0], pixa[7], pixa[8]);
        end
    endtask

    task automatic test_bg_disable();
        int nz;
        fill_mem(8'h01);
        set_in(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        clear_cap();
        start_line();
        capture(185);
        nz = 0;
        for (int x = 0; x < 160; x++) if (pixa[x] !== 2'b00) nz++;
        total++;
        if (nz !== 0) begin
            bad++;
            $display("FAIL bgoff_zero got %0d nonzero want 0", nz);
        end
        total++;
        if (first_v !== 9 || nvalid !== 160 || ld_cyc !== 169) begin
            bad++;
            $display("FAIL bgoff_timing got first=%0d n=%0d done=%0d want 9/160/169",
                     first_v, nvalid, ld_cyc);
        end
        total++;
        if (get_req(0) !== 13'h1800 || get_req(1) !== 13'h0010) begin
            bad++;
            $display("FAIL bgoff_req got %h %h want 1800 0010", get_req(0), get_req(1));
        end
    endtask

    task automatic test_restart();
        int nz, e;
        fill_mem(8'h01);
        set_in(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        clear_cap();
        start_line();
        capture(59);
        nz = 0;
        for (int x = 0; x < 51; x++) if (pixa[x] !== 2'b00) nz++;
        total++;
        if (nvalid !== 51 || nz !== 0 || nld !== 0) begin
            bad++;
            $display("FAIL abort_part got n=%0d nz=%0d done=%0d want 51/0/0", nvalid, nz, nld);
        end
        bg_ena = 1'b1;
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (first_v !== 9 || nvalid !== 160 || gap_err !== 0) begin
            bad++;
            $display("FAIL restart_first got cyc=%0d n=%0d gaps=%0d want 9/160/0",
                     first_v, nvalid, gap_err);
        end
        total++;
        if (nld !== 1 || ld_cyc !== 169) begin
            bad++;
            $display("FAIL restart_done got n=%0d cyc=%0d want 1/169", nld, ld_cyc);
        end
        e = pix_err(0);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL restart_pix got %0d wrong want 0", e);
        end
    endtask

    task automatic test_reset_mid();
        fill_mem(8'h01);
        set_in(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        start_line();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (vram_rd !== 1'b1 || vram_addr !== 13'h0010) begin
            bad++;
            $display("FAIL mid_loreq got rd=%b addr=%h want 1/0010", vram_rd, vram_addr);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({vram_rd, vram_addr, pix_valid, pix, pix_x, line_done} !== 26'h0) begin
            bad++;
            $display("FAIL mid_reset got rd=%b a=%h v=%b p=%0d x=%0d ld=%b want all 0",
                     vram_rd, vram_addr, pix_valid, pix, pix_x, line_done);
        end
        clear_cap();
        capture(30);
        total++;
        if (req.size() !== 0 || nvalid !== 0 || nld !== 0) begin
            bad++;
            $display("FAIL mid_quiet got rd=%0d v=%0d ld=%0d want 0/0/0",
                     req.size(), nvalid, nld);
        end
        clear_cap();
        start_line();
        capture(185);
        total++;
        if (first_v !== 9 || nvalid !== 160 || ld_cyc !== 169) begin
            bad++;
            $display("FAIL mid_again got first=%0d n=%0d done=%0d want 9/160/169",
                     first_v, nvalid, ld_cyc);
        end
    endtask

    initial begin
        pat[0] = 2'd3; pat[1] = 2'd3; pat[2] = 2'd1; pat[3] = 2'd1;
        pat[4] = 2'd2; pat[5] = 2'd2; pat[6] = 2'd0; pat[7] = 2'd0;
        fill_mem(8'h00);
        test_reset();
        test_baseline();
        test_8800();
        test_scroll();
        test_vwrap();
        test_bg_disable();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_bg_fetcher.md
# ppu_bg_fetcher

Background pixel pipeline for mode 3 of each visible scanline. It fetches tile-map and tile-data bytes from VRAM and decodes them into 2-bit colour indices in a 16-entry pixel FIFO. It then emits exactly 160 pixels, one per clock, to the LCD output stage. It sits downstream of the PPU timing engine, which supplies `ly`, the LCDC fields and a `line_start` pulse.

## Interface
- No parameters. Widths are fixed by the DMG memory map.
- `clk  in  1`: system clock. All state updates on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `line_start  in  1`: one-cycle pulse that starts the pixel transfer for the current line.
- `ly  in  8`: current scanline.
- `scx  in  8`, `scy  in  8`: background scroll. Sampled on the `line_start` cycle and held for the line.
- `bg_ena  in  1`, `bg_tile_map  in  1`, `bg_win_tile_data  in  1`: LCDC bits 0, 3 and 4. Sampled on the `line_start` cycle.
- `vram_rd  out  1`: VRAM read strobe.
- `vram_addr  out  13`: VRAM byte address, offset from 0x8000.
- `vram_data  in  8`: read data. Valid the cycle after `vram_rd`.
- `pix_valid  out  1`: `pix` and `pix_x` are valid this cycle.
- `pix  out  2`: colour index, before palette.
- `pix_x  out  8`: screen column, 0..159.
- `line_done  out  1`: one-cycle pulse after pixel 159.

## Operation
- **Fetcher FSM states:** IDLE, MAP_REQ, MAP_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, PUSH.
  - Each *_REQ state drives `vram_rd`=1 and `vram_addr`.
  - Each *_WAIT state registers `vram_data`.
  - PUSH writes 8 pixels when FIFO count ≤ 8, sampled before the same-cycle pop. Otherwise PUSH stalls.
  - After a push the FSM goes to MAP_REQ with tile counter `t`+1. `t` is 5 bits and cleared at `line_start`.
- **Address arithmetic** (8-bit values wrap modulo 256):
  - `y` = `ly` + `scy`.
  - Map column = ((`scx`>>3) + `t`) mod 32.
  - Map address = (`bg_tile_map` ? 0x1C00 : 0x1800) + `y`[7:3]·32 + map column.
  - Tile base, when `bg_win_tile_data`=1: tile·16, tile unsigned.
  - Tile base, when `bg_win_tile_data`=0: 0x1000 + signed(tile)·16, giving the range 0x0800..0x17F0.
  - Low-byte address = base + `y`[2:0]·2. High-byte address = low-byte address + 1.
- **Pixel decode:** pixel i (0 = leftmost) = {hi[7−i], lo[7−i]}. Pixels enter the FIFO in order i=0..7.
- **FIFO:** 16×2 bits with a count register; push of 8 and pop of 1 may occur in the same cycle.
- **Pop rule:** one pixel per cycle while the line is active and count > 0.
  - The first `scx`[2:0] pops of the line are discarded: no `pix_valid`.
  - Each later pop produces one output pixel.
- **Background disabled:** when `bg_ena`=0, VRAM fetches and timing are unchanged but every emitted `pix` is 0.
- **End of line:** after the pixel with `pix_x`=159:
  - `line_done` pulses;
  - the FSM returns to IDLE, the FIFO count clears and `vram_rd` drops;
  - further pops are suppressed.
- **Mid-line `line_start`:** flushes the FIFO, discard counter and `t`; re-samples the inputs and restarts at MAP_REQ. No `line_done` is issued for the aborted line.
- **Mid-line `reset`:** returns to IDLE in one edge.
- **Reset values:** all outputs 0, FSM IDLE, FIFO count 0.

## Timing
- Cycle 0: `line_start` high.
- Cycle 1: MAP_REQ. Cycle 3: LO_REQ. Cycle 5: HI_REQ. Cycle 7: PUSH. Cycle 8: count = 8, first pop.
- The steady fetch loop is 7 cycles per 8 pixels, so the FIFO never underflows after the first push.
- Output registers (`pix`, `pix_valid`, `pix_x`) update one cycle after their pop.
  - With `scx`[2:0]=d, `pix_x`=0 is valid in cycle 9+d.
  - `pix_x`=159 is valid in cycle 168+d.
  - `line_done` is high in cycle 169+d.
- `pix_valid` is contiguous: 160 consecutive cycles per line, no gaps.
- `vram_rd` is high only in *_REQ states, at most every other cycle.

## Test plan
- **Baseline line:** `scx`=`scy`=0, `ly`=0, map all 0x01, tile 1 row 0 = lo 0xF0 / hi 0xCC, 8000 addressing.
  - Requests at 0x1800, 0x0010, 0x0011.
  - Pixels repeat 3,3,1,1,2,2,0,0.
  - 160 contiguous `pix_valid` cycles, first in cycle 9; `line_done` in cycle 169.
- **8800 addressing:** `bg_win_tile_data`=0, map byte 0x80, `ly`=5 → low-byte read at 0x080A. Map byte 0x7F → 0x17FA.
- **Fine scroll and map wrap:** `scx`=0xFB.
  - First map read at column 31, second at column 0.
  - 3 pixels discarded; first valid pixel in cycle 12; `line_done` in cycle 172.
- **Vertical wrap and map select:** `ly`=250, `scy`=10, `bg_tile_map`=1 → `y`=4, map read at 0x1C00, tile row offset 8.
- **Background disabled, then restart:** `bg_ena`=0 → 160 zero pixels with unchanged timing.
  - `line_start` at pixel 50 → FIFO flushed, no `line_done`; new line restarts at `pix_x`=0 in cycle 9.
- **Reset mid-fetch:** `reset` asserted during LO_WAIT → next cycle all outputs 0, FSM IDLE. No activity until the next `line_start`.
